// File: rtl/ahb_region_resp_if.sv
// AHB-Lite uncore response interface: address-phase region select, slave returns, muxed bus response.
// The slave modport is the region response block; the master modport is the fabric/slave side.
// Parameter XLEN sets the data width of one slave slice.
interface ahb_region_resp_if #(
   parameter int XLEN = 64
);
   logic                 HSEL;
   logic [1:0]           HTRANS;
   logic [10:0]          HSELRegions;
   logic [10*XLEN-1:0]   HRDATAS;
   logic [9:0]           HREADYOUTS;
   logic [9:0]           HRESPS;
   logic [10:0]          HSELRegionsD;
   logic [XLEN-1:0]      HRDATA;
   logic                 HREADY;
   logic                 HRESP;

   modport slave (
      input  HSEL, HTRANS, HSELRegions, HRDATAS, HREADYOUTS, HRESPS,
      output HSELRegionsD, HRDATA, HREADY, HRESP
   );

   modport master (
      output HSEL, HTRANS, HSELRegions, HRDATAS, HREADYOUTS, HRESPS,
      input  HSELRegionsD, HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_region_resp.sv
// AHB-Lite data-phase region select register and response mux; two-cycle ERROR for unmapped hits.
// Latency: data returned in the cycle after the accepted address phase (zero-bubble back-to-back).
// Backpressure: slave HREADYOUT stalls the bus; optional stall watchdog via macro REGION_RESP_TIMEOUT_EN.
module ahb_region_resp #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic          clk,
   input  logic          reset,
   ahb_region_resp_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, ERR1, ERR2} state_t;

   state_t            state;
   logic [10:0]       sel_d;
   logic              accept;
   logic              load_err;
   logic              hready;
   logic              hresp;
   logic [XLEN-1:0]   hrdata;
   logic [XLEN-1:0]   slv_data;
   logic              slv_rdy;
   logic              slv_resp;
   logic              unused_htrans0;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..65535");
   end

`ifdef REGION_RESP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]  stall_cnt;
`endif

   // HTRANS[0] only distinguishes SEQ from NONSEQ, which this block treats alike
   assign unused_htrans0 = bus.HTRANS[0];

   assign accept   = hready & bus.HSEL & bus.HTRANS[1];
   assign load_err = bus.HSELRegions[0] | ~(|bus.HSELRegions);

   // Route the data-phase slave's returns; highest selected region wins if ever multi-hot
   always_comb begin
      slv_data = '0;
      slv_rdy  = 1'b1;
      slv_resp = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (sel_d[i]) begin
            slv_data = bus.HRDATAS[(i-1)*XLEN +: XLEN];
            slv_rdy  = bus.HREADYOUTS[i-1];
            slv_resp = bus.HRESPS[i-1];
         end
      end
   end

   // Bus response depends only on state, registered select and slave returns
   always_comb begin
      hrdata = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      case (state)
         BUSY: begin
            hrdata = slv_data;
            hready = slv_rdy;
            hresp  = slv_resp;
         end
         ERR1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         ERR2: begin
            hready = 1'b1;
            hresp  = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.HRDATA       = hrdata;
   assign bus.HREADY       = hready;
   assign bus.HRESP        = hresp;
   assign bus.HSELRegionsD = sel_d;

   // Data-phase sequencer: capture select on accept, run slave or error phases
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sel_d <= '0;
`ifdef REGION_RESP_TIMEOUT_EN
         stall_cnt <= '0;
`endif
      end else begin
`ifdef REGION_RESP_TIMEOUT_EN
         stall_cnt <= '0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  sel_d <= load_err ? 11'h001 : bus.HSELRegions;
                  state <= load_err ? ERR1 : BUSY;
               end
            end
            BUSY: begin
               if (hready) begin
                  if (accept) begin
                     sel_d <= load_err ? 11'h001 : bus.HSELRegions;
                     state <= load_err ? ERR1 : BUSY;
                  end else begin
                     sel_d <= '0;
                     state <= IDLE;
                  end
               end
`ifdef REGION_RESP_TIMEOUT_EN
               // A slave stalled too long is abandoned and answered with ERROR
               else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  sel_d <= 11'h001;
                  state <= ERR1;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
`endif
            end
            ERR1: state <= ERR2;
            ERR2: begin
               if (accept) begin
                  sel_d <= load_err ? 11'h001 : bus.HSELRegions;
                  state <= load_err ? ERR1 : BUSY;
               end else begin
                  sel_d <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_region_resp.sv
// Bench for ahb_region_resp: directed and random AHB traffic, scoreboard of expected transfer outcomes.
// A bus monitor pops one expectation per accepted address phase and checks every data-phase cycle.
// Build with REGION_RESP_TIMEOUT_EN to exercise the stall watchdog with TIMEOUT_CYCLES=4.
module tb_ahb_region_resp;
   localparam int XLEN = 64;
`ifdef REGION_RESP_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 256;
`endif
   localparam logic [9:0] ALL_RDY = 10'h3FF;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ahb_region_resp_if #(.XLEN(XLEN)) bus ();

   ahb_region_resp #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit err;
      int k;
   } exp_t;

   exp_t sbq[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   bit   mon_en  = 0;
   bit   pending = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Outcome of one accepted transfer: exactly one region bit 1..10 is a slave access, anything else errors
   function automatic exp_t model(input logic [10:0] r);
      exp_t e;
      e.err = 1'b1;
      e.k   = 0;
      for (int i = 1; i <= 10; i++) begin
         if (r == (11'(1) << i)) begin
            e.err = 1'b0;
            e.k   = i;
         end
      end
      return e;
   endfunction

   function automatic logic [10:0] pick_region();
      int r;
      r = $urandom_range(11, 0);
      if (r == 10) return 11'h001;
      if (r == 11) return 11'h000;
      return 11'(1) << (r + 1);
   endfunction

   // Bus monitor: phase 0 idle, 1 slave data, 2/3 first/second error cycle
   int   ph    = 0;
   int   stall = 0;
   exp_t cur;

   always @(negedge clk) begin
      logic [63:0] ed;
      logic        er;
      logic        es;
      logic [10:0] esel;
      bit          acc;
      if (mon_en) begin
         case (ph)
            1: begin
               ed   = bus.HRDATAS[(cur.k-1)*XLEN +: XLEN];
               er   = bus.HREADYOUTS[cur.k-1];
               es   = bus.HRESPS[cur.k-1];
               esel = 11'(1) << cur.k;
            end
            2: begin ed = '0; er = 1'b0; es = 1'b1; esel = 11'h001; end
            3: begin ed = '0; er = 1'b1; es = 1'b1; esel = 11'h001; end
            default: begin ed = '0; er = 1'b1; es = 1'b0; esel = 11'h000; end
         endcase
         chk("HRDATA", bus.HRDATA, ed);
         chk("HREADY", 64'(bus.HREADY), 64'(er));
         chk("HRESP", 64'(bus.HRESP), 64'(es));
         chk("HSELRegionsD", 64'(bus.HSELRegionsD), 64'(esel));
         chk("sel_onehot", 64'($onehot0(bus.HSELRegionsD[10:1])), 64'd1);
         acc = er && bus.HSEL && bus.HTRANS[1];
         if (reset) begin
            ph = 0;
            stall = 0;
            sbq.delete();
         end else if (ph == 2) begin
            ph = 3;
         end else if (ph == 1 && !er) begin
            stall++;
`ifdef REGION_RESP_TIMEOUT_EN
            if (stall == TO) begin
               ph = 2;
               stall = 0;
            end
`endif
         end else if (acc) begin
            n_chk++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: accept seen with empty queue at %0t", $time);
               ph = 0;
            end else begin
               cur = sbq.pop_front();
               ph = cur.err ? 2 : 1;
               stall = 0;
            end
         end else begin
            ph = 0;
         end
      end
   end

   // One bus cycle: slave returns refreshed every cycle, address held while a transfer waits for HREADY
   task automatic cycle(input logic rst, input logic sel, input logic [1:0] tr,
                        input logic [10:0] rg, input logic [9:0] ro);
      @(posedge clk);
      #1;
      reset = rst;
      bus.HREADYOUTS = ro;
      bus.HRESPS = 10'($urandom);
      for (int i = 0; i < 10; i++) bus.HRDATAS[i*XLEN +: XLEN] = {$urandom, $urandom};
      if (!pending || rst) begin
         bus.HSEL = sel;
         bus.HTRANS = tr;
         bus.HSELRegions = rg;
         if (!rst && sel && tr[1]) begin
            sbq.push_back(model(rg));
            pending = 1;
         end else begin
            pending = 0;
         end
      end
      @(negedge clk);
      if (pending && bus.HREADY) pending = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 2'b00, 11'h000, ALL_RDY);
   endtask

   initial begin
      bus.HSEL = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HSELRegions = '0;
      bus.HREADYOUTS = ALL_RDY;
      bus.HRESPS = '0;
      bus.HRDATAS = '0;
      repeat (2) cycle(1'b1, 1'b0, 2'b00, 11'h000, ALL_RDY);
      mon_en = 1;
      idle(3);

      // Single read from UART region, then unmapped and empty-select errors
      cycle(1'b0, 1'b1, 2'b10, 11'h008, ALL_RDY);
      idle(3);
      cycle(1'b0, 1'b1, 2'b10, 11'h001, ALL_RDY);
      idle(4);
      cycle(1'b0, 1'b1, 2'b11, 11'h000, ALL_RDY);
      idle(4);

      // Idle-type transfers must not be accepted
      cycle(1'b0, 1'b1, 2'b00, 11'h010, ALL_RDY);
      cycle(1'b0, 1'b1, 2'b01, 11'h010, ALL_RDY);
      cycle(1'b0, 1'b0, 2'b10, 11'h010, ALL_RDY);
      idle(2);

      // Back-to-back region 6 then region 10
      cycle(1'b0, 1'b1, 2'b10, 11'(1) << 6, ALL_RDY);
      cycle(1'b0, 1'b1, 2'b11, 11'(1) << 10, ALL_RDY);
      idle(3);

      // Region 5 stalls, reset lands mid-stall
      cycle(1'b0, 1'b1, 2'b10, 11'(1) << 5, ALL_RDY);
      cycle(1'b0, 1'b0, 2'b00, 11'h000, ~10'h010);
      cycle(1'b1, 1'b0, 2'b00, 11'h000, ~10'h010);
      cycle(1'b0, 1'b0, 2'b00, 11'h000, ~10'h010);
      idle(2);

      // Region 8 never ready for 100 cycles
      cycle(1'b0, 1'b1, 2'b10, 11'(1) << 8, ALL_RDY);
      repeat (100) cycle(1'b0, 1'b0, 2'b00, 11'h000, ~10'h080);
      idle(3);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic       r_rst;
         logic       r_sel;
         logic [1:0] r_tr;
         r_rst = ($urandom_range(199, 0) == 0);
         r_sel = ($urandom_range(3, 0) != 0);
         r_tr  = 2'($urandom);
         cycle(r_rst, r_rst ? 1'b0 : r_sel, r_tr, pick_region(),
               10'($urandom) | 10'($urandom));
      end
      idle(6);

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      chk("no_pending", 64'(pending), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
